// File: rtl/mbus_fault_pkg.sv
// mbus_fault_pkg: shared types for the MBUS fault-injection sequencer.
// FSM state encoding, fault MODE codes, default sizes, saturating helper.
package mbus_fault_pkg;

  localparam int MSG_W_DEF    = 8;
  localparam int EDGE_W_DEF   = 16;
  localparam int IDLE_CYC_DEF = 64;
  localparam int IDLE_W_DEF   = 7;

  typedef enum logic [2:0] {
    IDLE,
    SKIP,
    COUNT,
    INJECT,
    WAIT_END,
    FIN
  } state_t;

  typedef enum logic [1:0] {
    FMODE_NONE   = 2'd0,
    FMODE_TXERR  = 2'd1,
    FMODE_GLITCH = 2'd2,
    FMODE_BOTH   = 2'd3
  } fmode_t;

  function automatic logic [7:0] sat_inc8(
    input logic [7:0] v
  );
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/mbus_line_mon.sv
// mbus_line_mon: CIN/DIN synchroniser, CIN rise detect, idle tracker.
// Ports: clk, rst_n, cin, din in; cin_rise, bus_idle, msg_start out.
module mbus_line_mon #(
  parameter int IDLE_CYC = 64,
  parameter int IDLE_W   = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cin,
  input  logic din,
  output logic cin_rise,
  output logic bus_idle,
  output logic msg_start
);

  localparam logic [IDLE_W-1:0] IDLE_LAST =
    IDLE_W'(IDLE_CYC - 1);

  logic [1:0]        cin_ff;
  logic [1:0]        din_ff;
  logic              cin_d;
  logic              din_d;
  logic [IDLE_W-1:0] idle_cnt;
  logic              cin_s;
  logic              din_s;
  logic              both_hi;
  logic              idle_hit;

  assign cin_s    = cin_ff[1];
  assign din_s    = din_ff[1];
  assign both_hi  = cin_s & din_s;
  assign cin_rise = cin_s & ~cin_d;
  assign idle_hit = both_hi && (idle_cnt == IDLE_LAST);
  // A start is DIN falling while CIN is parked high on an idle bus.
  assign msg_start = ~din_s & din_d & cin_s & bus_idle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cin_ff   <= 2'b11;
      din_ff   <= 2'b11;
      cin_d    <= 1'b1;
      din_d    <= 1'b1;
      idle_cnt <= '0;
      bus_idle <= 1'b1;
    end else begin
      cin_ff <= {cin_ff[0], cin};
      din_ff <= {din_ff[0], din};
      cin_d  <= cin_s;
      din_d  <= din_s;
      if (!both_hi) begin
        idle_cnt <= '0;
      end else if (idle_cnt != IDLE_LAST) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
      if (msg_start) begin
        bus_idle <= 1'b0;
      end else if (idle_hit) begin
        bus_idle <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mbus_fault_sched.sv
// mbus_fault_sched: places a tx-error/glitch enable on a chosen MBUS
// message and bit. In: SYSCLK RESETn CIN DIN ARM ABORT MODE SKIP_MSGS
// EDGE_OFS WINDOW. Out: TXERR_EN GLITCH_EN BUSY DONE FAULT_CNT.
module mbus_fault_sched
  import mbus_fault_pkg::*;
#(
  parameter int MSG_W    = MSG_W_DEF,
  parameter int EDGE_W   = EDGE_W_DEF,
  parameter int IDLE_CYC = IDLE_CYC_DEF,
  parameter int IDLE_W   = IDLE_W_DEF
) (
  input  logic              SYSCLK,
  input  logic              RESETn,
  input  logic              CIN,
  input  logic              DIN,
  input  logic              ARM,
  input  logic              ABORT,
  input  logic [1:0]        MODE,
  input  logic [MSG_W-1:0]  SKIP_MSGS,
  input  logic [EDGE_W-1:0] EDGE_OFS,
  input  logic [EDGE_W-1:0] WINDOW,
  output logic              TXERR_EN,
  output logic              GLITCH_EN,
  output logic              BUSY,
  output logic              DONE,
  output logic [7:0]        FAULT_CNT
);

  localparam logic [EDGE_W-1:0] E_ONE = EDGE_W'(1);

  logic cin_rise;
  logic bus_idle;
  logic msg_start;

  state_t            state_q, state_n;
  logic [1:0]        mode_q;
  logic [EDGE_W-1:0] ofs_q;
  logic [EDGE_W-1:0] wcfg_q;
  logic [MSG_W-1:0]  skip_q, skip_n;
  logic [EDGE_W-1:0] edge_q, edge_n;
  logic [EDGE_W-1:0] win_q, win_n;
  logic              tx_q, tx_n;
  logic              gl_q, gl_n;
  logic [7:0]        fcnt_q, fcnt_n;
  logic              cfg_ld;
  logic [EDGE_W-1:0] win_ld;

  mbus_line_mon #(
    .IDLE_CYC (IDLE_CYC),
    .IDLE_W   (IDLE_W)
  ) u_mon (
    .clk       (SYSCLK),
    .rst_n     (RESETn),
    .cin       (CIN),
    .din       (DIN),
    .cin_rise  (cin_rise),
    .bus_idle  (bus_idle),
    .msg_start (msg_start)
  );

  assign win_ld = (wcfg_q == '0) ? E_ONE : wcfg_q;

  always_comb begin
    state_n = state_q;
    skip_n  = skip_q;
    edge_n  = edge_q;
    win_n   = win_q;
    tx_n    = 1'b0;
    gl_n    = 1'b0;
    fcnt_n  = fcnt_q;
    cfg_ld  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ARM) begin
          cfg_ld  = 1'b1;
          skip_n  = SKIP_MSGS;
          state_n = (MODE == FMODE_NONE) ? FIN : SKIP;
        end
      end
      SKIP: begin
        if (ABORT) begin
          state_n = FIN;
        end else if (msg_start) begin
          if (skip_q == '0) begin
            state_n = COUNT;
            edge_n  = ofs_q;
          end else begin
            skip_n = skip_q - 1'b1;
          end
        end
      end
      COUNT: begin
        if (ABORT || bus_idle) begin
          state_n = FIN;
        end else if (edge_q == '0 ||
                     (cin_rise && edge_q == E_ONE)) begin
          // Enables are flops so they rise with INJECT.
          state_n = INJECT;
          edge_n  = '0;
          win_n   = win_ld;
          tx_n    = mode_q[0];
          gl_n    = mode_q[1];
        end else if (cin_rise) begin
          edge_n = edge_q - E_ONE;
        end
      end
      INJECT: begin
        if (ABORT) begin
          state_n = FIN;
          fcnt_n  = sat_inc8(fcnt_q);
        end else if (bus_idle ||
                     (cin_rise && win_q <= E_ONE)) begin
          state_n = WAIT_END;
          fcnt_n  = sat_inc8(fcnt_q);
        end else begin
          tx_n = mode_q[0];
          gl_n = mode_q[1];
          if (cin_rise) begin
            win_n = win_q - E_ONE;
          end
        end
      end
      WAIT_END: begin
        if (ABORT || bus_idle) begin
          state_n = FIN;
        end
      end
      FIN: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge SYSCLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= IDLE;
      mode_q  <= '0;
      ofs_q   <= '0;
      wcfg_q  <= '0;
      skip_q  <= '0;
      edge_q  <= '0;
      win_q   <= '0;
      tx_q    <= 1'b0;
      gl_q    <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_n;
      skip_q  <= skip_n;
      edge_q  <= edge_n;
      win_q   <= win_n;
      tx_q    <= tx_n;
      gl_q    <= gl_n;
      fcnt_q  <= fcnt_n;
      if (cfg_ld) begin
        mode_q <= MODE;
        ofs_q  <= EDGE_OFS;
        wcfg_q <= WINDOW;
      end
    end
  end

  assign TXERR_EN  = tx_q;
  assign GLITCH_EN = gl_q;
  assign BUSY      = (state_q != IDLE);
  assign DONE      = (state_q == FIN);
  assign FAULT_CNT = fcnt_q;

endmodule

// File: doc/mbus_fault_sched.md
Name: mbus_fault_sched

Overview:
Sequencer for the MBUS fault-injection generators (tx-error corruptor and glitch generator) that sit between an ICE node's DOUT and the bus. It watches the node's CIN/DIN, skips a programmed number of messages, counts CIN rising edges to a programmed bit position, then asserts the selected generator's enable for a programmed window. Used in regression benches and ICE debug builds, so a fault lands on a deterministic message and bit instead of being toggled around a whole command.

Parameters:
MSG_W, 8, width of message-skip count
EDGE_W, 16, width of edge-offset and window counts
IDLE_CYC, 64, consecutive SYSCLK cycles with CIN=DIN=1 that declare the bus idle (message end)
IDLE_W, 7, counter width for IDLE_CYC (must hold IDLE_CYC)

Ports:
SYSCLK  in  1  system clock; single clock domain
RESETn  in  1  asynchronous active-low reset
CIN  in  1  MBUS clock seen by the node (asynchronous to SYSCLK)
DIN  in  1  MBUS data seen by the node (asynchronous to SYSCLK)
ARM  in  1  one-cycle pulse; latches config and starts a run
ABORT  in  1  one-cycle pulse; ends any run
MODE  in  2  0 none, 1 txerr, 2 glitch, 3 both
SKIP_MSGS  in  MSG_W  messages to let pass before the target
EDGE_OFS  in  EDGE_W  CIN rising edges after target start before injection
WINDOW  in  EDGE_W  CIN rising edges the enable stays high; 0 is treated as 1
TXERR_EN  out  1  enable to the tx-error generator
GLITCH_EN  out  1  enable to the glitch generator
BUSY  out  1  high from ARM until DONE or ABORT
DONE  out  1  one-cycle pulse at run completion
FAULT_CNT  out  8  completed injections since reset; saturates at 255

Behaviour:
- Reset: every output is 0, state IDLE, sync flops 1, idle flag 1, counters 0.
- Sync: CIN and DIN each pass through 2 flops. Edge detects run on the synced values. Detection latency from the pin is 2–3 SYSCLK.
- Idle tracker:
  - idle_cnt increments while synced CIN=DIN=1 and clears otherwise.
  - bus_idle sets when idle_cnt reaches IDLE_CYC-1 and clears on msg_start.
  - msg_start = synced DIN falling while synced CIN=1 and bus_idle=1.
- ARM: latches MODE/SKIP_MSGS/EDGE_OFS/WINDOW into shadow registers. ARM is ignored while BUSY. Config ports are don't-care after ARM.
- FSM:
  - IDLE: on ARM go to SKIP (BUSY=1). If MODE=0, go straight to FIN instead, with no enable asserted.
  - SKIP: if skip_cnt=0, wait for msg_start and go to COUNT. Otherwise each msg_start decrements skip_cnt and stays in SKIP. The target message is the (SKIP_MSGS+1)-th start after ARM.
  - COUNT: edge_cnt loads EDGE_OFS on entry and decrements on each synced CIN rise.
    - Reaching 0 goes to INJECT. EDGE_OFS=0 enters INJECT in the cycle after msg_start.
    - If bus_idle sets first (message shorter than offset), go to FIN with no injection; FAULT_CNT is unchanged.
  - INJECT: TXERR_EN = MODE[0], GLITCH_EN = MODE[1], both registered and asserted the cycle INJECT is entered. win_cnt loads max(WINDOW,1) and decrements on CIN rises; reaching 0 or bus_idle goes to WAIT_END. FAULT_CNT increments on exit.
  - WAIT_END: enables low; wait for bus_idle=1, then go to FIN.
  - FIN: DONE=1 for one cycle, BUSY=0 next, go to IDLE.
- ABORT in any non-IDLE state: enables drop next cycle, DONE pulses, go to IDLE. FAULT_CNT increments only if aborted in INJECT. ABORT takes priority over every other event in the same cycle.
- ARM and msg_start in the same cycle: the start is not counted; counting begins at the next start.
- Counters never wrap: decrements stop at 0 and FAULT_CNT saturates at 255.
- Async RESETn mid-run: immediate return to reset values; enables drop combinationally via the flop reset.

Decomposition:
- Shared package mbus_fault_pkg holds:
  - state encoding (IDLE, SKIP, COUNT, INJECT, WAIT_END, FIN);
  - MODE constants (FMODE_NONE, FMODE_TXERR, FMODE_GLITCH, FMODE_BOTH);
  - default parameter values.
- One sub-module, mbus_line_mon: 2-flop sync, CIN-rise detect, idle tracker and msg_start. The FSM/counter logic stays in the top.

Test Plan:
1. MODE=1, SKIP=0, EDGE_OFS=5, WINDOW=1, one 32-bit MBUS message -> TXERR_EN high from about the 5th CIN rise after start to the 6th; GLITCH_EN stays 0; DONE after idle; FAULT_CNT=1.
2. MODE=2, SKIP=2, EDGE_OFS=10, WINDOW=4, three messages -> messages 1–2 untouched; GLITCH_EN high for 4 CIN rises in message 3 only; FAULT_CNT=1.
3. MODE=3, EDGE_OFS=200, 40-edge message -> no enable ever asserted; DONE pulses at idle; FAULT_CNT unchanged.
4. ABORT pulsed 2 edges into INJECT (MODE=1, WINDOW=8) -> TXERR_EN low next cycle; DONE pulse; BUSY=0; FAULT_CNT+1.
5. Second ARM while BUSY with different config -> ignored; run completes with the original config. MODE=0 ARM -> DONE within 2 cycles, BUSY 1 for ≤2 cycles.
6. RESETn asserted mid-INJECT -> all outputs 0 immediately; after release, a new ARM works normally.
